// File: rtl/wb_periph_fabric.sv
// Wishbone peripheral fabric: split read/write master channels fanned out to NUM_SLOTS slots.
// Optional ack timeout is compiled in with the WB_FABRIC_TIMEOUT_EN macro.
module wb_periph_fabric #(
  parameter int NUM_SLOTS      = 4,
  parameter int ADDR_BITS      = 16,
  parameter int XLEN           = 32,
  parameter int SLOT_LSB       = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      sync_reset,
  input  logic                      WB_RD_STB_I,
  input  logic [ADDR_BITS-1:0]      WB_RD_ADR_I,
  output logic [XLEN-1:0]           WB_RD_DAT_O,
  output logic                      WB_RD_ACK_O,
  input  logic                      WB_WR_STB_I,
  input  logic                      WB_WR_WE_I,
  input  logic [XLEN/8-1:0]         WB_WR_SEL_I,
  input  logic [ADDR_BITS-1:0]      WB_WR_ADR_I,
  input  logic [XLEN-1:0]           WB_WR_DAT_I,
  output logic                      WB_WR_ACK_O,
  output logic [NUM_SLOTS-1:0]      S_RD_STB_O,
  output logic [ADDR_BITS-1:0]      S_RD_ADR_O,
  input  logic [NUM_SLOTS*XLEN-1:0] S_RD_DAT_I,
  input  logic [NUM_SLOTS-1:0]      S_RD_ACK_I,
  output logic [NUM_SLOTS-1:0]      S_WR_STB_O,
  output logic [XLEN/8-1:0]         S_WR_SEL_O,
  output logic [ADDR_BITS-1:0]      S_WR_ADR_O,
  output logic [XLEN-1:0]           S_WR_DAT_O,
  input  logic [NUM_SLOTS-1:0]      S_WR_ACK_I,
  input  logic [NUM_SLOTS-1:0]      s_int_req,
  output logic                      int_gen,
  output logic                      bus_error,
  output logic [1:0]                err_code
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [1:0] ERR_DECODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t rd_state, rd_state_n, wr_state, wr_state_n;

  logic [SW-1:0]        rd_slot_in, wr_slot_in, rd_slot, wr_slot;
  logic                 rd_slot_ok, wr_slot_ok;
  logic                 wr_req;
  logic [NUM_SLOTS-1:0] rd_onehot, wr_onehot;
  logic                 rd_ack_hit, wr_ack_hit;
  logic [XLEN-1:0]      rd_slot_dat;
  logic                 rd_cap, rd_ack_set, rd_take, rd_err;
  logic                 wr_cap, wr_ack_set, wr_err;
  logic [1:0]           rd_err_code, wr_err_code;

  // A single slot needs no index field; every address maps to slot 0.
  generate
    if (NUM_SLOTS > 1) begin : g_dec
      assign rd_slot_in = WB_RD_ADR_I[SLOT_LSB +: SW];
      assign wr_slot_in = WB_WR_ADR_I[SLOT_LSB +: SW];
    end else begin : g_dec_single
      assign rd_slot_in = '0;
      assign wr_slot_in = '0;
    end
  endgenerate

  assign rd_slot_ok = 32'(rd_slot_in) < NUM_SLOTS;
  assign wr_slot_ok = 32'(wr_slot_in) < NUM_SLOTS;
  assign wr_req     = WB_WR_STB_I & WB_WR_WE_I;

  assign rd_onehot  = NUM_SLOTS'(1) << rd_slot;
  assign wr_onehot  = NUM_SLOTS'(1) << wr_slot;
  assign rd_ack_hit = |(S_RD_ACK_I & rd_onehot);
  assign wr_ack_hit = |(S_WR_ACK_I & wr_onehot);

  assign S_RD_STB_O = (rd_state == REQ) ? rd_onehot : '0;
  assign S_WR_STB_O = (wr_state == REQ) ? wr_onehot : '0;

  always_comb begin
    rd_slot_dat = '0;
    for (int k = 0; k < NUM_SLOTS; k++)
      if (rd_slot == SW'(k)) rd_slot_dat = S_RD_DAT_I[k*XLEN +: XLEN];
  end

`ifdef WB_FABRIC_TIMEOUT_EN
  logic [15:0] rd_cnt, wr_cnt;
  logic        rd_tmo, wr_tmo;

  // Counters are zero on the first WAIT cycle because they clear while in REQ.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_state == REQ)       rd_cnt <= '0;
      else if (rd_state == WAIT) rd_cnt <= rd_cnt + 16'd1;
      if (wr_state == REQ)       wr_cnt <= '0;
      else if (wr_state == WAIT) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  assign rd_tmo = (rd_state == WAIT) && (rd_cnt == 16'(TIMEOUT_CYCLES));
  assign wr_tmo = (wr_state == WAIT) && (wr_cnt == 16'(TIMEOUT_CYCLES));
`endif

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      rd_state <= IDLE;
      wr_state <= IDLE;
    end else begin
      rd_state <= rd_state_n;
      wr_state <= wr_state_n;
    end
  end

  always_comb begin
    rd_state_n  = rd_state;
    rd_cap      = 1'b0;
    rd_ack_set  = 1'b0;
    rd_take     = 1'b0;
    rd_err      = 1'b0;
    rd_err_code = 2'b00;
    case (rd_state)
      IDLE: begin
        if (WB_RD_STB_I) begin
          if (rd_slot_ok) begin
            rd_cap     = 1'b1;
            rd_state_n = REQ;
          end else begin
            rd_ack_set  = 1'b1;
            rd_err      = 1'b1;
            rd_err_code = ERR_DECODE;
          end
        end
      end
      REQ: begin
        rd_state_n = WAIT;
        if (WB_RD_STB_I) begin
          rd_err      = 1'b1;
          rd_err_code = ERR_OVERRUN;
        end
      end
      WAIT: begin
        if (WB_RD_STB_I) begin
          rd_err      = 1'b1;
          rd_err_code = ERR_OVERRUN;
        end
        if (rd_ack_hit) begin
          rd_ack_set = 1'b1;
          rd_take    = 1'b1;
          rd_state_n = IDLE;
        end
`ifdef WB_FABRIC_TIMEOUT_EN
        else if (rd_tmo) begin
          rd_ack_set  = 1'b1;
          rd_err      = 1'b1;
          rd_err_code = ERR_TIMEOUT;
          rd_state_n  = IDLE;
        end
`endif
      end
      default: rd_state_n = IDLE;
    endcase
  end

  always_comb begin
    wr_state_n  = wr_state;
    wr_cap      = 1'b0;
    wr_ack_set  = 1'b0;
    wr_err      = 1'b0;
    wr_err_code = 2'b00;
    case (wr_state)
      IDLE: begin
        if (wr_req) begin
          if (wr_slot_ok) begin
            wr_cap     = 1'b1;
            wr_state_n = REQ;
          end else begin
            wr_ack_set  = 1'b1;
            wr_err      = 1'b1;
            wr_err_code = ERR_DECODE;
          end
        end
      end
      REQ: begin
        wr_state_n = WAIT;
        if (wr_req) begin
          wr_err      = 1'b1;
          wr_err_code = ERR_OVERRUN;
        end
      end
      WAIT: begin
        if (wr_req) begin
          wr_err      = 1'b1;
          wr_err_code = ERR_OVERRUN;
        end
        if (wr_ack_hit) begin
          wr_ack_set = 1'b1;
          wr_state_n = IDLE;
        end
`ifdef WB_FABRIC_TIMEOUT_EN
        else if (wr_tmo) begin
          wr_ack_set  = 1'b1;
          wr_err      = 1'b1;
          wr_err_code = ERR_TIMEOUT;
          wr_state_n  = IDLE;
        end
`endif
      end
      default: wr_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      rd_slot     <= '0;
      S_RD_ADR_O  <= '0;
      WB_RD_ACK_O <= 1'b0;
      WB_RD_DAT_O <= '0;
      wr_slot     <= '0;
      S_WR_ADR_O  <= '0;
      S_WR_SEL_O  <= '0;
      S_WR_DAT_O  <= '0;
      WB_WR_ACK_O <= 1'b0;
      bus_error   <= 1'b0;
      err_code    <= 2'b00;
      int_gen     <= 1'b0;
    end else begin
      if (rd_cap) begin
        rd_slot    <= rd_slot_in;
        S_RD_ADR_O <= WB_RD_ADR_I;
      end
      WB_RD_ACK_O <= rd_ack_set;
      WB_RD_DAT_O <= rd_take ? rd_slot_dat : '0;
      if (wr_cap) begin
        wr_slot    <= wr_slot_in;
        S_WR_ADR_O <= WB_WR_ADR_I;
        S_WR_SEL_O <= WB_WR_SEL_I;
        S_WR_DAT_O <= WB_WR_DAT_I;
      end
      WB_WR_ACK_O <= wr_ack_set;
      bus_error   <= rd_err | wr_err;
      // Read channel wins when both report in the same cycle.
      if (rd_err)      err_code <= rd_err_code;
      else if (wr_err) err_code <= wr_err_code;
      int_gen <= |s_int_req;
    end
  end

endmodule
